inst_queue: RTL

Circular instruction buffer between instruction fetch and the reorder buffer. It accepts raw 32-bit instructions with their PC from fetch and decodes the fields the ROB consumes: packed opcode, rd, rs1, rs2 and sign-extended immediate. It presents the oldest entry to the ROB with a valid/full handshake and discards its contents on a branch flush. It decouples fetch latency from ROB occupancy.

---
 rtl/inst_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and the ROB, with field decode of the head entry.
// Optional same-cycle bypass of an incoming word into an empty queue: define IQ_BYPASS_EN.
module inst_queue #(
  parameter int unsigned IQ_DEPTH_LOG = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        iq_full,
  input  logic        flush_in,
  input  logic        rob_full,
  output logic        have_input,
  output logic [31:0] instr_input,
  output logic [31:0] instr_input_pc,
  output logic [16:0] opcode_if,
  output logic [4:0]  rd_if,
  output logic [4:0]  rs1_if,
  output logic [4:0]  rs2_if,
  output logic [31:0] imm_if
);

  localparam int unsigned Depth = 1 << IQ_DEPTH_LOG;
  localparam logic [IQ_DEPTH_LOG:0] FullCnt = Depth[IQ_DEPTH_LOG:0];

  logic [31:0]             instr_mem [Depth];
  logic [31:0]             pc_mem    [Depth];
  logic [IQ_DEPTH_LOG-1:0] head, tail;
  logic [IQ_DEPTH_LOG:0]   count;
  logic                    queued, bypass, enq, deq;
  logic [31:0]             instr;

  assign iq_full = (count == FullCnt);
  assign queued  = (count != '0);

`ifdef IQ_BYPASS_EN
  // An empty queue forwards the fetch word directly; it is written only if the ROB stalls.
  assign bypass         = rdy_in && !queued && if_valid && !flush_in;
  assign have_input     = queued || bypass;
  assign instr          = bypass ? if_instr : instr_mem[head];
  assign instr_input_pc = bypass ? if_pc : pc_mem[head];
`else
  assign bypass         = 1'b0;
  assign have_input     = queued;
  assign instr          = instr_mem[head];
  assign instr_input_pc = pc_mem[head];
`endif

  assign enq = rdy_in && if_valid && !iq_full && !flush_in && !(bypass && !rob_full);
  assign deq = rdy_in && queued && !rob_full && !flush_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          instr_mem[tail] <= if_instr;
          pc_mem[tail]    <= if_pc;
          tail            <= tail + 1'b1;
        end
        if (deq) head <= head + 1'b1;
        if (enq && !deq) count <= count + 1'b1;
        else if (deq && !enq) count <= count - 1'b1;
      end
    end
  end

  assign instr_input = instr;
  assign opcode_if   = {instr[31:25], instr[14:12], instr[6:0]};
  assign rd_if       = instr[11:7];
  assign rs1_if      = instr[19:15];
  assign rs2_if      = instr[24:20];

  always_comb begin
    imm_if = '0;
    case (instr[6:0])
      7'b0000011, 7'b1100111: imm_if = {{20{instr[31]}}, instr[31:20]};
      7'b0010011: begin
        // Shift-immediates carry a shamt, not a signed immediate.
        if (instr[13:12] == 2'b01) imm_if = {27'b0, instr[24:20]};
        else                       imm_if = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: imm_if = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011: imm_if = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_if = {instr[31:12], 12'b0};
      7'b1101111: imm_if = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
      default: imm_if = '0;
    endcase
  end

endmodule
